// File: rtl/motor_pkg.sv
// Shared types and constants for the H-bridge motor drive sequencer:
// FSM state encoding, level-to-compare-value table and direction pin patterns.
package motor_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RAMP  = 3'd1,
      ST_RUN   = 3'd2,
      ST_BRAKE = 3'd3,
      ST_DEAD  = 3'd4,
      ST_FAULT = 3'd5
   } state_t;

   localparam logic [1:0] DIR_A_FWD = 2'b10;
   localparam logic [1:0] DIR_A_REV = 2'b01;
   localparam logic [1:0] DIR_B_FWD = 2'b01;
   localparam logic [1:0] DIR_B_REV = 2'b10;
   localparam logic [1:0] DIR_COAST = 2'b00;

   // Quarter-scale compare values, evaluated at elaboration only (shifts and adds).
   function automatic logic [17:0] level_value(input int period, input int quarter);
      case (quarter)
         0:       return 18'd0;
         1:       return 18'(period / 4);
         2:       return 18'(period / 2);
         3:       return 18'((period / 2) + (period / 4));
         default: return 18'(period);
      endcase
   endfunction

   function automatic logic [1:0] pins_a(input logic dir);
      return dir ? DIR_A_FWD : DIR_A_REV;
   endfunction

   function automatic logic [1:0] pins_b(input logic dir);
      return dir ? DIR_B_FWD : DIR_B_REV;
   endfunction

endpackage

// File: rtl/oc_filter.sv
// Overcurrent debounce: counts consecutive sense-high cycles, saturates at LIMIT
// and emits a single-cycle trip pulse on the cycle the count reaches LIMIT.
module oc_filter #(
   parameter int LIMIT = 249999
) (
   input  logic clk,
   input  logic rst,
   input  logic sense,
   input  logic clr,
   output logic trip
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt  <= '0;
         trip <= 1'b0;
      end else if (!sense) begin
         cnt  <= '0;
         trip <= 1'b0;
      end else begin
         // Pulse only on the transition into saturation, never while held there.
         trip <= (cnt == CW'(LIMIT - 1));
         if (cnt != CW'(LIMIT))
            cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/motor_drive_sequencer.sv
// Command sequencer for the two-channel H-bridge: ramps the PWM compare value,
// inserts brake and dead time before reversals, and latches overcurrent faults.
import motor_pkg::*;

module motor_drive_sequencer #(
   parameter int PERIOD    = 250000,
   parameter int RAMP_TICK = 2500,
   parameter int RAMP_STEP = 6250,
   parameter int DEAD_CYC  = 100000,
   parameter int OC_LIMIT  = 249999
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_dir,
   input  logic [2:0]  cmd_level,
   input  logic        oc_sense,
   input  logic        oc_clear,
   output logic [17:0] pulse_width,
   output logic [1:0]  dir_a,
   output logic [1:0]  dir_b,
   output logic        fault,
   output logic [2:0]  state
);

   localparam int TW = (RAMP_TICK > 1) ? $clog2(RAMP_TICK) : 1;
   localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC + 1) : 1;
   localparam logic [17:0] STEP = 18'(RAMP_STEP);
   localparam logic [17:0] LVL0 = level_value(PERIOD, 0);
   localparam logic [17:0] LVL1 = level_value(PERIOD, 1);
   localparam logic [17:0] LVL2 = level_value(PERIOD, 2);
   localparam logic [17:0] LVL3 = level_value(PERIOD, 3);
   localparam logic [17:0] LVL4 = level_value(PERIOD, 4);

   state_t        st;
   logic          cur_dir;
   logic          pend_dir;
   logic [17:0]   target;
   logic [17:0]   pend_target;
   logic [17:0]   cmd_target;
   logic [17:0]   ramp_pw;
   logic [TW-1:0] tick_cnt;
   logic [DW-1:0] dead_cnt;
   logic          tick;
   logic          trip;
   logic          oc_clr;
   logic          accept;
   logic          same_path;

   // One step toward tgt, landing exactly on tgt when closer than a step.
   function automatic logic [17:0] ramp_next(input logic [17:0] cur, input logic [17:0] tgt);
      if (cur < tgt)
         return ((tgt - cur) > STEP) ? cur + STEP : tgt;
      else
         return ((cur - tgt) > STEP) ? cur - STEP : tgt;
   endfunction

   always_comb begin
      cmd_target = LVL4;
      case (cmd_level)
         3'd0:    cmd_target = LVL0;
         3'd1:    cmd_target = LVL1;
         3'd2:    cmd_target = LVL2;
         3'd3:    cmd_target = LVL3;
         default: cmd_target = LVL4;
      endcase
   end

   assign state     = st;
   assign tick      = (tick_cnt == TW'(RAMP_TICK - 1));
   assign accept    = cmd_valid && cmd_ready;
   assign same_path = (cmd_dir == cur_dir) || (pulse_width == 18'd0);
   assign oc_clr    = (st == ST_FAULT) && oc_clear && !oc_sense;
   assign ramp_pw   = ramp_next(pulse_width, (st == ST_BRAKE) ? 18'd0 : target);

   oc_filter #(.LIMIT(OC_LIMIT)) u_oc_filter (
      .clk   (clk),
      .rst   (rst),
      .sense (oc_sense),
      .clr   (oc_clr),
      .trip  (trip)
   );

   always_ff @(posedge clk) begin
      if (rst || tick)
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st          <= ST_IDLE;
         pulse_width <= 18'd0;
         dir_a       <= DIR_A_FWD;
         dir_b       <= DIR_B_FWD;
         fault       <= 1'b0;
         cmd_ready   <= 1'b1;
         cur_dir     <= 1'b1;
         target      <= 18'd0;
         pend_dir    <= 1'b1;
         pend_target <= 18'd0;
         dead_cnt    <= '0;
      end else if (trip) begin
         // A trip outranks any handshake or dead-time completion this cycle.
         st          <= ST_FAULT;
         pulse_width <= 18'd0;
         dir_a       <= DIR_COAST;
         dir_b       <= DIR_COAST;
         fault       <= 1'b1;
         cmd_ready   <= 1'b0;
         target      <= 18'd0;
      end else begin
         case (st)
            ST_IDLE, ST_RAMP, ST_RUN: begin
               if (accept) begin
                  if (same_path) begin
                     cur_dir <= cmd_dir;
                     target  <= cmd_target;
                     dir_a   <= pins_a(cmd_dir);
                     dir_b   <= pins_b(cmd_dir);
                     st      <= (cmd_target == 18'd0 && pulse_width == 18'd0) ? ST_IDLE : ST_RAMP;
                  end else begin
                     pend_dir    <= cmd_dir;
                     pend_target <= cmd_target;
                     cmd_ready   <= 1'b0;
                     st          <= ST_BRAKE;
                  end
               end else if (st == ST_RAMP && tick) begin
                  pulse_width <= ramp_pw;
                  if (ramp_pw == target)
                     st <= (target == 18'd0) ? ST_IDLE : ST_RUN;
               end
            end
            ST_BRAKE: begin
               if (tick) begin
                  pulse_width <= ramp_pw;
                  if (ramp_pw == 18'd0) begin
                     st       <= ST_DEAD;
                     dir_a    <= DIR_COAST;
                     dir_b    <= DIR_COAST;
                     dead_cnt <= '0;
                  end
               end
            end
            ST_DEAD: begin
               if (dead_cnt == DW'(DEAD_CYC - 1)) begin
                  cur_dir   <= pend_dir;
                  target    <= pend_target;
                  dir_a     <= pins_a(pend_dir);
                  dir_b     <= pins_b(pend_dir);
                  cmd_ready <= 1'b1;
                  st        <= (pend_target == 18'd0) ? ST_IDLE : ST_RAMP;
               end else begin
                  dead_cnt <= dead_cnt + 1'b1;
               end
            end
            ST_FAULT: begin
               if (oc_clear && !oc_sense) begin
                  st        <= ST_IDLE;
                  fault     <= 1'b0;
                  cmd_ready <= 1'b1;
                  dir_a     <= pins_a(cur_dir);
                  dir_b     <= pins_b(cur_dir);
               end
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_motor_drive_sequencer.sv
// Directed self-checking bench for motor_drive_sequencer at reduced timing parameters.
module tb_motor_drive_sequencer;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RAMP  = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_BRAKE = 3'd3;
   localparam logic [2:0] S_DEAD  = 3'd4;
   localparam logic [2:0] S_FAULT = 3'd5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_dir = 1'b1;
   logic [2:0]  cmd_level = 3'd0;
   logic        oc_sense = 1'b0;
   logic        oc_clear = 1'b0;
   logic [17:0] pulse_width;
   logic [1:0]  dir_a;
   logic [1:0]  dir_b;
   logic        fault;
   logic [2:0]  state;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   motor_drive_sequencer #(
      .PERIOD(400), .RAMP_TICK(4), .RAMP_STEP(50), .DEAD_CYC(10), .OC_LIMIT(20)
   ) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_dir(cmd_dir), .cmd_level(cmd_level), .oc_sense(oc_sense),
      .oc_clear(oc_clear), .pulse_width(pulse_width), .dir_a(dir_a),
      .dir_b(dir_b), .fault(fault), .state(state)
   );

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic d, input logic [2:0] l);
      cmd_valid = 1'b1;
      cmd_dir   = d;
      cmd_level = l;
      cyc();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_pw(input logic [17:0] v, input int budget, output logic ok);
      ok = (pulse_width == v);
      for (int i = 0; i < budget && !ok; i++) begin
         cyc();
         ok = (pulse_width == v);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      total++; if (pulse_width !== 18'd0) begin bad++; $display("FAIL reset_pw got=%0d want=0", pulse_width); end
      total++; if (dir_a !== 2'b10) begin bad++; $display("FAIL reset_dir_a got=%b want=10", dir_a); end
      total++; if (dir_b !== 2'b01) begin bad++; $display("FAIL reset_dir_b got=%b want=01", dir_b); end
      total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b want=0", fault); end
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", cmd_ready); end
      total++; if (state !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", state, S_IDLE); end
   endtask

   task automatic test_ramp_up;
      logic [17:0] expv;
      logic [17:0] prev;
      int gap;
      int steps;
      send(1'b1, 3'd4);
      total++; if (state !== S_RAMP) begin bad++; $display("FAIL ramp_enter got=%0d want=%0d", state, S_RAMP); end
      expv = 18'd50; prev = 18'd0; gap = 0; steps = 0;
      for (int i = 0; i < 100 && steps < 8; i++) begin
         cyc();
         gap++;
         if (pulse_width !== prev) begin
            total++; if (pulse_width !== expv) begin bad++; $display("FAIL ramp_step got=%0d want=%0d", pulse_width, expv); end
            if (steps > 0) begin
               total++; if (gap != 4) begin bad++; $display("FAIL ramp_gap got=%0d want=4", gap); end
            end
            prev = pulse_width; expv = expv + 18'd50; gap = 0; steps++;
         end
      end
      total++; if (steps != 8) begin bad++; $display("FAIL ramp_steps got=%0d want=8", steps); end
      total++; if (pulse_width !== 18'd400) begin bad++; $display("FAIL ramp_final got=%0d want=400", pulse_width); end
      total++; if (state !== S_RUN) begin bad++; $display("FAIL ramp_run got=%0d want=%0d", state, S_RUN); end
      total++; if (dir_a !== 2'b10 || dir_b !== 2'b01) begin bad++; $display("FAIL ramp_pins got=%b%b want=1001", dir_a, dir_b); end
   endtask

   task automatic test_retarget;
      logic ok;
      logic [17:0] minv;
      logic [17:0] maxv;
      send(1'b1, 3'd1);
      minv = pulse_width;
      for (int i = 0; i < 60; i++) begin
         cyc();
         if (pulse_width < minv) minv = pulse_width;
      end
      total++; if (minv !== 18'd100) begin bad++; $display("FAIL down_min got=%0d want=100", minv); end
      total++; if (pulse_width !== 18'd100) begin bad++; $display("FAIL down_final got=%0d want=100", pulse_width); end
      total++; if (state !== S_RUN) begin bad++; $display("FAIL down_run got=%0d want=%0d", state, S_RUN); end
      send(1'b1, 3'd4);
      wait_pw(18'd200, 40, ok);
      total++; if (!ok) begin bad++; $display("FAIL retarget_reach200 got=%0d want=200", pulse_width); end
      send(1'b1, 3'd3);
      maxv = pulse_width;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (pulse_width > maxv) maxv = pulse_width;
      end
      total++; if (maxv !== 18'd300) begin bad++; $display("FAIL retarget_max got=%0d want=300", maxv); end
      total++; if (pulse_width !== 18'd300) begin bad++; $display("FAIL retarget_final got=%0d want=300", pulse_width); end
      total++; if (state !== S_RUN) begin bad++; $display("FAIL retarget_run got=%0d want=%0d", state, S_RUN); end
   endtask

   task automatic test_reversal;
      logic ok;
      int n;
      send(1'b1, 3'd2);
      wait_pw(18'd200, 40, ok);
      cyc(4);
      total++; if (!ok || state !== S_RUN) begin bad++; $display("FAIL rev_setup got=%0d/%0d want=200/%0d", pulse_width, state, S_RUN); end
      send(1'b0, 3'd2);
      total++; if (state !== S_BRAKE) begin bad++; $display("FAIL rev_brake got=%0d want=%0d", state, S_BRAKE); end
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rev_ready got=%b want=0", cmd_ready); end
      wait_pw(18'd0, 40, ok);
      total++; if (!ok) begin bad++; $display("FAIL rev_to_zero got=%0d want=0", pulse_width); end
      total++; if (state !== S_DEAD) begin bad++; $display("FAIL rev_dead got=%0d want=%0d", state, S_DEAD); end
      total++; if (dir_a !== 2'b00 || dir_b !== 2'b00) begin bad++; $display("FAIL rev_coast got=%b%b want=0000", dir_a, dir_b); end
      n = 1;
      for (int i = 0; i < 30 && dir_a == 2'b00; i++) begin
         cyc();
         if (dir_a == 2'b00) n++;
      end
      total++; if (n != 10) begin bad++; $display("FAIL rev_dead_len got=%0d want=10", n); end
      total++; if (dir_a !== 2'b01 || dir_b !== 2'b10) begin bad++; $display("FAIL rev_pins got=%b%b want=0110", dir_a, dir_b); end
      total++; if (state !== S_RAMP || cmd_ready !== 1'b1) begin bad++; $display("FAIL rev_ramp got=%0d/%b want=%0d/1", state, cmd_ready, S_RAMP); end
      wait_pw(18'd200, 40, ok);
      cyc(2);
      total++; if (!ok || state !== S_RUN) begin bad++; $display("FAIL rev_final got=%0d/%0d want=200/%0d", pulse_width, state, S_RUN); end
   endtask

   task automatic test_oc_filter;
      oc_sense = 1'b1;
      cyc(19);
      oc_sense = 1'b0;
      cyc();
      total++; if (fault !== 1'b0 || state !== S_RUN) begin bad++; $display("FAIL oc_short got=%b/%0d want=0/%0d", fault, state, S_RUN); end
      total++; if (pulse_width !== 18'd200) begin bad++; $display("FAIL oc_short_pw got=%0d want=200", pulse_width); end
      cyc(2);
      oc_sense = 1'b1;
      cyc(20);
      total++; if (fault !== 1'b0) begin bad++; $display("FAIL oc_early got=%b want=0", fault); end
      cyc();
      total++; if (fault !== 1'b1) begin bad++; $display("FAIL oc_trip got=%b want=1", fault); end
      total++; if (pulse_width !== 18'd0) begin bad++; $display("FAIL oc_pw got=%0d want=0", pulse_width); end
      total++; if (dir_a !== 2'b00 || dir_b !== 2'b00) begin bad++; $display("FAIL oc_pins got=%b%b want=0000", dir_a, dir_b); end
      total++; if (state !== S_FAULT || cmd_ready !== 1'b0) begin bad++; $display("FAIL oc_state got=%0d/%b want=%0d/0", state, cmd_ready, S_FAULT); end
   endtask

   task automatic test_fault_clear;
      logic ok;
      oc_clear = 1'b1;
      cyc();
      total++; if (state !== S_FAULT || fault !== 1'b1) begin bad++; $display("FAIL clr_blocked got=%0d/%b want=%0d/1", state, fault, S_FAULT); end
      oc_sense = 1'b0;
      cyc();
      oc_clear = 1'b0;
      total++; if (state !== S_IDLE || fault !== 1'b0) begin bad++; $display("FAIL clr_exit got=%0d/%b want=%0d/0", state, fault, S_IDLE); end
      total++; if (cmd_ready !== 1'b1 || pulse_width !== 18'd0) begin bad++; $display("FAIL clr_out got=%b/%0d want=1/0", cmd_ready, pulse_width); end
      total++; if (dir_a !== 2'b01 || dir_b !== 2'b10) begin bad++; $display("FAIL clr_pins got=%b%b want=0110", dir_a, dir_b); end
      send(1'b1, 3'd1);
      total++; if (state !== S_RAMP || dir_a !== 2'b10) begin bad++; $display("FAIL clr_cmd got=%0d/%b want=%0d/10", state, dir_a, S_RAMP); end
      wait_pw(18'd100, 40, ok);
      total++; if (!ok) begin bad++; $display("FAIL clr_ramp got=%0d want=100", pulse_width); end
   endtask

   task automatic test_reset_mid;
      logic seen;
      cyc(4);
      send(1'b0, 3'd4);
      seen = (state == S_DEAD);
      for (int i = 0; i < 40 && !seen; i++) begin
         cyc();
         seen = (state == S_DEAD);
      end
      total++; if (!seen) begin bad++; $display("FAIL mid_dead got=%0d want=%0d", state, S_DEAD); end
      cyc(3);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      total++; if (state !== S_IDLE || pulse_width !== 18'd0) begin bad++; $display("FAIL mid_rst got=%0d/%0d want=%0d/0", state, pulse_width, S_IDLE); end
      total++; if (dir_a !== 2'b10 || dir_b !== 2'b01 || cmd_ready !== 1'b1 || fault !== 1'b0) begin
         bad++; $display("FAIL mid_rst_out got=%b%b/%b/%b want=1001/1/0", dir_a, dir_b, cmd_ready, fault);
      end
      cyc(30);
      total++; if (state !== S_IDLE || pulse_width !== 18'd0 || dir_a !== 2'b10) begin
         bad++; $display("FAIL mid_discard got=%0d/%0d/%b want=%0d/0/10", state, pulse_width, dir_a, S_IDLE);
      end
      oc_sense = 1'b1;
      cyc(21);
      total++; if (state !== S_FAULT || fault !== 1'b1) begin bad++; $display("FAIL mid_fault got=%0d/%b want=%0d/1", state, fault, S_FAULT); end
      rst = 1'b1;
      oc_sense = 1'b0;
      cyc();
      rst = 1'b0;
      total++; if (state !== S_IDLE || fault !== 1'b0 || cmd_ready !== 1'b1) begin
         bad++; $display("FAIL fault_rst got=%0d/%b/%b want=%0d/0/1", state, fault, cmd_ready, S_IDLE);
      end
      total++; if (dir_a !== 2'b10 || dir_b !== 2'b01 || pulse_width !== 18'd0) begin
         bad++; $display("FAIL fault_rst_out got=%b%b/%0d want=1001/0", dir_a, dir_b, pulse_width);
      end
   endtask

   initial begin
      test_reset();
      test_ramp_up();
      test_retarget();
      test_reversal();
      test_oc_filter();
      test_fault_clear();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/motor_drive_sequencer.md
# motor_drive_sequencer

Sequences the two-channel H-bridge motor PWM datapath: accepts speed/direction commands, ramps the PWM compare value toward each target, and forces a brake-then-dead-time sequence before any direction reversal. It also filters the bridge overcurrent sense into a latched fault that removes drive until cleared. It sits between the switch/command front end and the 400 Hz PWM comparator, and drives both the comparator's `pulse_width` and the bridge direction pins.

## Interface
- `PERIOD`, 250000: PWM carrier period in clk cycles; full-scale `pulse_width`.
- `RAMP_TICK`, 2500: clk cycles between ramp steps.
- `RAMP_STEP`, 6250: `pulse_width` change per ramp step.
- `DEAD_CYC`, 100000: cycles with both direction pins low between brake and reversal.
- `OC_LIMIT`, 249999: consecutive `oc_sense` high cycles that trip a fault.
- `clk` in 1: system clock, 100 MHz. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_dir` in 1: 1 = forward, 0 = reverse.
- `cmd_level` in 3: 0..4 quarters of `PERIOD`. Values 5..7 clamp to 4.
- `oc_sense` in 1: raw overcurrent comparator input, already synchronised.
- `oc_clear` in 1: fault clear request.
- `pulse_width` out 18: PWM compare value, 0..`PERIOD`.
- `dir_a` out 2: Motor A {IN1, IN2}. Forward = 2'b10, reverse = 2'b01, coast = 2'b00.
- `dir_b` out 2: Motor B {IN1, IN2}. Forward = 2'b01, reverse = 2'b10, coast = 2'b00.
- `fault` out 1: overcurrent latched.
- `state` out 3: current FSM state, for the seven-segment display.

## Operation
- States: IDLE, RAMP, RUN, BRAKE, DEAD, FAULT.
- Target: `target = level*PERIOD/4`, using constants 0, 62500, 125000, 187500, 250000. No multiplier.
- `cmd_ready` is 1 in IDLE, RAMP and RUN. It is 0 in BRAKE, DEAD and FAULT.
- Command with the same direction as `cur_dir`, or with `pulse_width` == 0:
  - Latch `cur_dir` and `target`.
  - Go to RAMP, or to IDLE if the target is 0 and `pulse_width` is 0.
- Command with the opposite direction and `pulse_width` > 0:
  - Latch the new direction into `pend_dir` and the new target into `pend_target`.
  - Go to BRAKE.
- RAMP: on each ramp tick, move `pulse_width` by `RAMP_STEP` toward `target`. Saturate exactly at `target`; never overshoot.
  - Reaching `target` > 0 goes to RUN.
  - Reaching 0 goes to IDLE.
- Retargeting in RAMP or RUN takes effect on the next tick and does not restart the tick counter.
- BRAKE: ramp toward 0 with the same rule. At 0, go to DEAD.
- DEAD:
  - Both direction outputs are 2'b00 for `DEAD_CYC` cycles.
  - Then `cur_dir <= pend_dir` and `target <= pend_target`.
  - Go to RAMP, or to IDLE if the target is 0.
- IDLE and RUN drive the direction pins from `cur_dir`. `pulse_width` is held constant in both.
- Overcurrent filter:
  - The counter increments while `oc_sense` = 1 and clears to 0 when `oc_sense` = 0.
  - It saturates at `OC_LIMIT`.
  - Reaching `OC_LIMIT` trips the fault, from any state.
- FAULT:
  - `pulse_width` = 0 and both direction outputs = 2'b00.
  - `fault` = 1 and `cmd_ready` = 0.
  - Exit to IDLE only when `oc_clear` = 1 and `oc_sense` = 0 in the same cycle. The exit clears the filter count.
- Trip priority:
  - A trip beats a command handshake in the same cycle; the command is not accepted.
  - A trip beats the DEAD completion in the same cycle.

## Timing
- Reset values:
  - `pulse_width` = 0.
  - `dir_a` = 2'b10, `dir_b` = 2'b01 (forward, `cur_dir` = 1).
  - `fault` = 0, `cmd_ready` = 1, `state` = IDLE.
  - Tick, dead-time and filter counters = 0.
- Reset mid-operation, including in FAULT, returns to these values on the next edge.
- All outputs are registered.
- Command acceptance: the state changes on the cycle after the handshake. The first ramp step comes at the next tick boundary, at most `RAMP_TICK` cycles later.
- The ramp tick counter free-runs from reset; it wraps at `RAMP_TICK`-1.
- Fault: `pulse_width` = 0 and `fault` = 1 exactly 1 cycle after the filter count reaches `OC_LIMIT`. That is `OC_LIMIT`+1 edges after `oc_sense` rises.
- Worst-case full-scale reversal time: 2*(`PERIOD`/`RAMP_STEP`)*`RAMP_TICK` + `DEAD_CYC` cycles.

## Structure
- Shared package `motor_pkg`:
  - State enum.
  - The five level constants.
  - Direction pin encodings for the forward, reverse and coast patterns.
- Sub-module `oc_filter`: parameter `LIMIT`; ports `clk`, `rst`, `sense`, `clr` in; `trip` out (a 1-cycle pulse at saturation).
- Everything else is one FSM with ramp, tick and dead-time counters.

## Test plan
Test parameters: `PERIOD`=400, `RAMP_TICK`=4, `RAMP_STEP`=50, `DEAD_CYC`=10, `OC_LIMIT`=20.
1. Reset, then forward level 4 -> `pulse_width` steps 50, 100, ..., 400, one step per 4 cycles. RUN is entered; `dir_a`=10, `dir_b`=01.
2. In RUN at 400, forward level 1 -> ramps down to 100 and stays in RUN. Level 3 issued mid-ramp retargets to 300 with no overshoot.
3. In RUN at 200 forward, reverse level 2:
   - `cmd_ready` drops; the value ramps to 0.
   - Direction pins are 00 for 10 cycles.
   - Then `dir_a`=01, `dir_b`=10 and the value ramps to 200.
4. `oc_sense` high for 19 cycles then low -> no fault. High for 20 cycles -> `fault`=1 and `pulse_width`=0 one cycle later, pins 00.
5. In FAULT, `oc_clear` while `oc_sense`=1 -> stays in FAULT. `oc_clear` with `oc_sense`=0 -> IDLE. A subsequent command is accepted.
6. `rst` asserted during DEAD and again during FAULT -> all reset values on the next edge. The pending reversal is discarded.
